// File: rtl/layer1_out_serializer.sv
// Layer-1 output serializer: captures a NUM_CH x DW vector into a two-slot
// ping-pong buffer and streams it out one channel word per accepted cycle.
module layer1_out_serializer #(
  parameter int unsigned NUM_CH = 32,
  parameter int unsigned DW     = 32,
  localparam int unsigned CW    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 valid_out_layer1,
  input  logic [NUM_CH*DW-1:0] data_in,
  input  logic                 out_ready,
  output logic                 out_valid,
  output logic [DW-1:0]        out_data,
  output logic [CW-1:0]        out_ch,
  output logic                 out_last,
  output logic                 overflow,
  output logic [7:0]           drop_cnt
);

  localparam int unsigned VW      = NUM_CH * DW;
  localparam logic [CW-1:0] LAST_CH = CW'(NUM_CH - 1);

  logic [VW-1:0] r_slot [2];
  logic          r_wr_ptr;
  logic          r_rd_ptr;
  logic [1:0]    r_count;
  logic [CW-1:0] r_ch_idx;
  logic          r_overflow;
  logic [7:0]    r_drop_cnt;

  logic          w_valid;
  logic          w_pop;
  logic          w_last_pop;
  logic          w_cap;
  logic          w_drop;
  logic [DW-1:0] w_word;

  // Handshake decode; a last-word pop frees a slot in time for a same-edge capture
  assign w_valid    = (r_count != 2'd0);
  assign w_pop      = w_valid & out_ready;
  assign w_last_pop = w_pop & (r_ch_idx == LAST_CH);
  assign w_cap      = valid_out_layer1 & ((r_count != 2'd2) | w_last_pop);
  assign w_drop     = valid_out_layer1 & ~w_cap;
  assign w_word     = r_slot[r_rd_ptr][r_ch_idx*DW +: DW];

  // Read mux off registered state only; data forced to zero while empty
  assign out_valid = w_valid;
  assign out_data  = w_valid ? w_word : '0;
  assign out_ch    = r_ch_idx;
  assign out_last  = w_valid & (r_ch_idx == LAST_CH);
  assign overflow  = r_overflow;
  assign drop_cnt  = r_drop_cnt;

  // Vector storage is pure datapath; occupancy tracking makes its reset value irrelevant
  always_ff @(posedge clk) begin
    if (w_cap) begin
      r_slot[r_wr_ptr] <= data_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= 1'b0;
      r_rd_ptr   <= 1'b0;
      r_count    <= 2'd0;
      r_ch_idx   <= '0;
      r_overflow <= 1'b0;
      r_drop_cnt <= 8'd0;
    end else begin
      if (w_cap) begin
        r_wr_ptr <= ~r_wr_ptr;
      end

      if (w_last_pop) begin
        r_ch_idx <= '0;
        r_rd_ptr <= ~r_rd_ptr;
      end else if (w_pop) begin
        r_ch_idx <= r_ch_idx + CW'(1);
      end

      unique case ({w_cap, w_last_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase

      if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_drop_cnt != 8'hFF) begin
          r_drop_cnt <= r_drop_cnt + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_layer1_out_serializer.sv
// Self-checking bench for layer1_out_serializer: scoreboard of expected words,
// table-driven buffer scenarios, and hand-written reset/saturation/random runs.
module tb_layer1_out_serializer;

  localparam int unsigned NUM_CH = 32;
  localparam int unsigned DW     = 32;
  localparam int unsigned VW     = NUM_CH * DW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          valid_out_layer1;
  logic [VW-1:0] data_in;
  logic          out_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic [4:0]    out_ch;
  logic          out_last;
  logic          overflow;
  logic [7:0]    drop_cnt;

  layer1_out_serializer #(.NUM_CH(NUM_CH), .DW(DW)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .valid_out_layer1 (valid_out_layer1),
    .data_in          (data_in),
    .out_ready        (out_ready),
    .out_valid        (out_valid),
    .out_data         (out_data),
    .out_ch           (out_ch),
    .out_last         (out_last),
    .overflow         (overflow),
    .drop_cnt         (drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    logic [4:0]  ch;
    logic        last;
  } exp_t;

  typedef struct {
    bit          rst_before;
    int          gap;
    bit          rdy;
    logic [31:0] base;
    bit          accept;
    bit          drain;
    bit          exp_ovf;
    int          exp_drop;
  } row_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  row_t tbl [10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [VW-1:0] mkvec(input logic [31:0] base);
    logic [VW-1:0] v;
    for (int k = 0; k < NUM_CH; k++) v[k*DW +: DW] = base + 32'(k);
    return v;
  endfunction

  task automatic push_vec(input logic [31:0] base);
    exp_t e;
    for (int k = 0; k < NUM_CH; k++) begin
      e.d = base + 32'(k);
      e.ch = 5'(k);
      e.last = (k == NUM_CH - 1);
      sb.push_back(e);
    end
  endtask

  // One clock: inputs applied now, held across the next rising edge
  task automatic cyc(input logic v, input logic [VW-1:0] d, input logic r);
    valid_out_layer1 = v;
    data_in = d;
    out_ready = r;
    @(posedge clk);
    #1;
    valid_out_layer1 = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_data"}, 64'(out_data), 64'd0);
    chk({tag, "_ch"}, 64'(out_ch), 64'd0);
    chk({tag, "_last"}, 64'(out_last), 64'd0);
    chk({tag, "_ovf"}, 64'(overflow), 64'd0);
    chk({tag, "_drop"}, 64'(drop_cnt), 64'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    sb.delete();
    repeat (3) cyc(1'b0, '0, 1'b0);
    chk_reset_outputs("reset");
    rst_n = 1'b1;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 5000) begin
      cyc(1'b0, '0, 1'b1);
      n++;
    end
    chk("drain_empty", 64'(sb.size()), 64'd0);
    cyc(1'b0, '0, 1'b1);
    chk("drain_idle", 64'(out_valid), 64'd0);
  endtask

  // Counts consecutive valid cycles with ready=1, optionally injecting a second vector
  task automatic count_run(input int inject_at, input logic [31:0] b2, output int n);
    n = 0;
    for (int i = 0; i < 200; i++) begin
      if (!out_valid) break;
      n++;
      if (i == inject_at) begin
        cyc(1'b1, mkvec(b2), 1'b1);
        push_vec(b2);
      end else begin
        cyc(1'b0, '0, 1'b1);
      end
    end
  endtask

  // Pops are compared against the scoreboard; stalled outputs must hold
  task automatic monitor();
    exp_t e;
    bit stall_prev = 1'b0;
    logic [31:0] h_d;
    logic [4:0] h_ch;
    logic h_last;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stall_prev = 1'b0;
      end else begin
        if (stall_prev) begin
          checks++;
          if (!(out_valid && out_data == h_d && out_ch == h_ch && out_last == h_last)) begin
            errors++;
            $display("FAIL stall_stable: got v=%0b d=%0h ch=%0d last=%0b held d=%0h ch=%0d last=%0b",
                     out_valid, out_data, out_ch, out_last, h_d, h_ch, h_last);
          end
        end
        if (out_valid && out_ready) begin
          checks++;
          if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_word: got d=%0h ch=%0d, expected none", out_data, out_ch);
          end else begin
            e = sb.pop_front();
            if (out_data !== e.d || out_ch !== e.ch || out_last !== e.last) begin
              errors++;
              $display("FAIL word: got d=%0h ch=%0d last=%0b expected d=%0h ch=%0d last=%0b at %0t",
                       out_data, out_ch, out_last, e.d, e.ch, e.last, $time);
            end
          end
        end
        stall_prev = out_valid && !out_ready;
        h_d = out_data;
        h_ch = out_ch;
        h_last = out_last;
      end
    end
  endtask

  initial begin
    int n;
    logic [31:0] b;
    rst_n = 1'b0;
    valid_out_layer1 = 1'b0;
    data_in = '0;
    out_ready = 1'b0;

    //            rst gap rdy base           acc drain ovf drop
    tbl[0] = '{1'b1, 2, 1'b0, 32'hA000_0000, 1'b1, 1'b0, 1'b0, 0};
    tbl[1] = '{1'b0, 0, 1'b0, 32'hA100_0000, 1'b1, 1'b0, 1'b0, 0};
    tbl[2] = '{1'b0, 0, 1'b0, 32'hA200_0000, 1'b0, 1'b1, 1'b1, 1};
    tbl[3] = '{1'b0, 3, 1'b0, 32'hA300_0000, 1'b1, 1'b1, 1'b1, 1};
    tbl[4] = '{1'b1, 2, 1'b1, 32'hB000_0000, 1'b1, 1'b0, 1'b0, 0};
    tbl[5] = '{1'b0, 0, 1'b1, 32'hB100_0000, 1'b1, 1'b0, 1'b0, 0};
    tbl[6] = '{1'b0, 30, 1'b1, 32'hB200_0000, 1'b1, 1'b1, 1'b0, 0};
    tbl[7] = '{1'b1, 2, 1'b1, 32'hC000_0000, 1'b1, 1'b0, 1'b0, 0};
    tbl[8] = '{1'b0, 0, 1'b1, 32'hC100_0000, 1'b1, 1'b0, 1'b0, 0};
    tbl[9] = '{1'b0, 29, 1'b1, 32'hC200_0000, 1'b0, 1'b1, 1'b1, 1};

    fork
      monitor();
    join_none

    // Single vector on the first edge after reset release
    do_reset();
    cyc(1'b1, mkvec(32'h1000_0000), 1'b1);
    push_vec(32'h1000_0000);
    count_run(-1, '0, n);
    chk("single_run_len", 64'(n), 64'd32);
    chk("single_sb_empty", 64'(sb.size()), 64'd0);

    // Two vectors one idle cycle apart stream without gaps
    do_reset();
    cyc(1'b1, mkvec(32'h2000_0000), 1'b1);
    push_vec(32'h2000_0000);
    count_run(1, 32'h2100_0000, n);
    chk("double_run_len", 64'(n), 64'd64);
    chk("double_ovf", 64'(overflow), 64'd0);

    // Buffer scenarios: fill/drop, same-edge capture on last pop, one-edge-early drop
    for (int i = 0; i < 10; i++) begin
      if (tbl[i].rst_before) do_reset();
      repeat (tbl[i].gap) cyc(1'b0, '0, tbl[i].rdy);
      cyc(1'b1, mkvec(tbl[i].base), tbl[i].rdy);
      if (tbl[i].accept) push_vec(tbl[i].base);
      if (tbl[i].drain) begin
        drain();
        chk($sformatf("row%0d_ovf", i), 64'(overflow), 64'(tbl[i].exp_ovf));
        chk($sformatf("row%0d_drop", i), 64'(drop_cnt), 64'(tbl[i].exp_drop));
      end
    end

    // drop_cnt saturates at 255
    do_reset();
    for (int i = 0; i < 260; i++) begin
      cyc(1'b1, mkvec(32'h3000_0000 + 32'(i << 8)), 1'b0);
      if (i < 2) push_vec(32'h3000_0000 + 32'(i << 8));
    end
    chk("sat_drop", 64'(drop_cnt), 64'd255);
    chk("sat_ovf", 64'(overflow), 64'd1);
    drain();

    // Reset mid-vector after channel 10
    do_reset();
    cyc(1'b1, mkvec(32'h4000_0000), 1'b1);
    push_vec(32'h4000_0000);
    repeat (11) cyc(1'b0, '0, 1'b1);
    chk("mid_ch_before_rst", 64'(out_ch), 64'd11);
    rst_n = 1'b0;
    sb.delete();
    #1;
    chk_reset_outputs("async_rst");
    repeat (2) cyc(1'b0, '0, 1'b1);
    rst_n = 1'b1;
    cyc(1'b1, mkvec(32'h5000_0000), 1'b1);
    push_vec(32'h5000_0000);
    chk("post_rst_ch0", 64'(out_ch), 64'd0);
    chk("post_rst_data0", 64'(out_data), 64'h5000_0000);
    drain();
    chk("post_rst_drop", 64'(drop_cnt), 64'd0);

    // Random backpressure over 884 vectors spaced 40 cycles apart
    do_reset();
    for (int v = 0; v < 884; v++) begin
      b = $urandom;
      cyc(1'b1, mkvec(b), ($urandom_range(0, 7) != 0));
      push_vec(b);
      repeat (39) cyc(1'b0, '0, ($urandom_range(0, 7) != 0));
    end
    drain();
    chk("rand_ovf", 64'(overflow), 64'd0);
    chk("rand_drop", 64'(drop_cnt), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
